// File: rtl/apb_master_arbiter.sv
// APB3 master shared round-robin by N_REQ requesters; IDLE/SETUP/ACCESS with PREADY timeout.
// Zero-wait latency handshake->rsp_valid is 3 cycles; req_ready is raised only while the bus can accept a command.
module apb_master_arbiter #(
  parameter int N_REQ   = 2,
  parameter int ID_W    = 1,
  parameter int TIMEOUT = 16
) (
  input  logic               PCLK,
  input  logic               PRESETn,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ-1:0]   req_write,
  input  logic [N_REQ*9-1:0] req_addr,
  input  logic [N_REQ*8-1:0] req_wdata,
  output logic [N_REQ-1:0]   req_ready,
  output logic               rsp_valid,
  output logic [ID_W-1:0]    rsp_id,
  output logic [7:0]         rsp_rdata,
  output logic               rsp_err,
  output logic               PSEL1,
  output logic               PSEL2,
  output logic               PENABLE,
  output logic               PWRITE,
  output logic [8:0]         PADDR,
  output logic [7:0]         PWDATA,
  input  logic [7:0]         PRDATA,
  input  logic               PREADY,
  input  logic               PSLVERR
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SETUP = 2'd1, S_ACCESS = 2'd2} state_e;

  localparam int CNT_W = $clog2(TIMEOUT + 2);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e           state_q, state_d;
  logic [ID_W-1:0]  last_grant_q, last_grant_d;
  logic [ID_W-1:0]  owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cap_write_q, cap_write_d;
  logic [8:0]       cap_addr_q, cap_addr_d;
  logic [7:0]       cap_wdata_q, cap_wdata_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
  logic [7:0]       rsp_rdata_q, rsp_rdata_d;
  logic             rsp_err_q, rsp_err_d;

  logic [ID_W-1:0]  scan_idx, win_idx;
  logic             win_found;
  logic             sel_write;
  logic [8:0]       sel_addr;
  logic [7:0]       sel_wdata;
  logic             grant_open, handshake, xfer_done, timeout_hit;

  // Scan starts one past the previous winner so every requester is reached within N_REQ grants.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      scan_idx = ID_W'((int'(last_grant_q) + k) % N_REQ);
      if (!win_found && req_valid[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_idx == ID_W'(i)) begin
        sel_write = req_write[i];
        sel_addr  = req_addr[i*9 +: 9];
        sel_wdata = req_wdata[i*8 +: 8];
      end
    end
  end

  assign xfer_done   = (state_q == S_ACCESS) && PREADY;
  assign timeout_hit = (TIMEOUT != 0) && (state_q == S_ACCESS) && !PREADY && (cnt_q == TMO_LAST);
  assign grant_open  = (state_q == S_IDLE) || xfer_done;
  assign handshake   = grant_open && win_found;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i] = handshake && (win_idx == ID_W'(i));
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (handshake) state_d = S_SETUP;
      S_SETUP:  state_d = S_ACCESS;
      S_ACCESS: begin
        if (PREADY)           state_d = handshake ? S_SETUP : S_IDLE;
        else if (timeout_hit) state_d = S_IDLE;
      end
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    PSEL1     = (state_q != S_IDLE) && !cap_addr_q[8];
    PSEL2     = (state_q != S_IDLE) &&  cap_addr_q[8];
    PENABLE   = (state_q == S_ACCESS);
    PWRITE    = cap_write_q;
    PADDR     = cap_addr_q;
    PWDATA    = cap_wdata_q;
    rsp_valid = rsp_valid_q;
    rsp_id    = rsp_id_q;
    rsp_rdata = rsp_rdata_q;
    rsp_err   = rsp_err_q;
  end

  always_comb begin
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    cap_write_d  = cap_write_q;
    cap_addr_d   = cap_addr_q;
    cap_wdata_d  = cap_wdata_q;
    cnt_d        = cnt_q;
    if (handshake) begin
      last_grant_d = win_idx;
      owner_d      = win_idx;
      cap_write_d  = sel_write;
      cap_addr_d   = sel_addr;
      cap_wdata_d  = sel_wdata;
      cnt_d        = '0;
    end else if ((state_q == S_ACCESS) && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
    // PSLVERR only counts on the PREADY cycle; an abort always reports an error with no data.
    rsp_valid_d = xfer_done || timeout_hit;
    rsp_id_d    = rsp_valid_d ? owner_q : rsp_id_q;
    rsp_rdata_d = (xfer_done && !cap_write_q) ? PRDATA : 8'h00;
    rsp_err_d   = xfer_done ? PSLVERR : timeout_hit;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q      <= S_IDLE;
      last_grant_q <= ID_W'(N_REQ - 1);
      owner_q      <= '0;
      cnt_q        <= '0;
      cap_write_q  <= 1'b0;
      cap_addr_q   <= '0;
      cap_wdata_q  <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      cap_write_q  <= cap_write_d;
      cap_addr_q   <= cap_addr_d;
      cap_wdata_q  <= cap_wdata_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

endmodule
